mat_result_reader: RTL and testbench
====================================

MAT_RESULT_READER -- requirements
Module: mat_result_reader

Interface
REQ-001 Parameter ELEM_W, default 17, SHALL be the width of one result element.
REQ-002 Parameter N, default 3, SHALL be the matrix dimension; NUM_ELEM = N*N.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 in_valid  input  1  SHALL be the multiplier result-valid level.
REQ-006 in_mat  input  NUM_ELEM*ELEM_W  SHALL be the result matrix, ascending bit order, element 0 (row 0, col 0) in bits [0:ELEM_W-1], row-major.
REQ-007 out_valid  output  1  SHALL flag out_data/out_index/out_last as valid.
REQ-008 out_ready  input  1  SHALL be the downstream accept signal.
REQ-009 out_data  output  ELEM_W  SHALL be the current element.
REQ-010 out_index  output  4  SHALL be the current element index, 0..NUM_ELEM-1.
REQ-011 out_last  output  1  SHALL be high with the final element (index NUM_ELEM-1).
REQ-012 busy  output  1  SHALL be high in SEND and DONE.
REQ-013 done  output  1  SHALL pulse one cycle after the last transfer.
REQ-014 overrun  output  1  SHALL be a sticky flag for a result dropped while busy.

Function
REQ-015 FSM states SHALL be IDLE, SEND, DONE.
REQ-016 A capture event SHALL be in_valid high in a cycle where it was low the previous cycle (rising edge); a level held high SHALL NOT re-trigger.
REQ-017 IDLE + capture event at edge k: in_mat SHALL be latched into an internal buffer, index cleared, state -> SEND; out_valid SHALL be high from the cycle after edge k.
REQ-018 SEND: out_data SHALL equal buffer element out_index; a transfer occurs on a rising edge with out_valid && out_ready.
REQ-019 While out_valid && !out_ready, out_data, out_index, out_last SHALL hold stable.
REQ-020 Each transfer SHALL increment out_index by 1; transfer at index NUM_ELEM-1 SHALL move to DONE with out_valid low the next cycle.
REQ-021 With out_ready tied high, NUM_ELEM elements SHALL stream on NUM_ELEM consecutive cycles.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-023 A capture event in SEND or DONE SHALL be ignored (buffer unchanged) and SHALL set overrun; overrun SHALL clear only on reset.
REQ-024 A capture event in the same cycle DONE returns to IDLE SHALL be ignored and SHALL set overrun; a new frame requires a fresh rising edge seen in IDLE.
REQ-025 out_data SHALL be zero whenever out_valid is low.

Reset
REQ-026 reset_n low at a rising edge SHALL force state IDLE, buffer zero, out_valid 0, out_data 0, out_index 0, out_last 0, busy 0, done 0, overrun 0, previous in_valid sample 0, in any state including mid-stream.
REQ-027 If in_valid is high at reset release, that SHALL count as a rising edge (previous sample 0) and start a frame.

Structure
REQ-028 Shared package mat_pkg SHALL hold ELEM_W, N, NUM_ELEM, and the FSM state type.
REQ-029 The block SHALL be a single module; no sub-module is required.

Verification
REQ-030 in_mat elements 1..9, out_ready=1, in_valid 0->1 at cycle 5: out_valid cycles 6-14, out_data 1..9, out_last only at cycle 14 (index 8), done=1 at cycle 15, busy low at cycle 16.
REQ-031 Backpressure: out_ready low 3 cycles while out_index=4 -> out_data holds 5, index 4 for those cycles; stream then completes 6..9 unchanged.
REQ-032 in_valid held high through done and 10 further cycles -> no second frame, overrun stays 0; drop then raise in_valid -> new frame captured.
REQ-033 Second in_valid rising edge at out_index 3 with different in_mat -> overrun=1, remaining outputs still from original buffer.
REQ-034 reset_n low for one cycle at out_index 5 -> next cycle out_valid=0, out_index=0, busy=0, overrun=0; following capture restarts at index 0.
REQ-035 All elements 17'h1FFFF -> out_data 17'h1FFFF for all 9 transfers, no truncation.

Source files
------------

// File: rtl/mat_pkg.sv
// mat_pkg: shared dimensions and FSM state type for the matrix result reader
package mat_pkg;
    localparam int ELEM_W   = 17;
    localparam int N        = 3;
    localparam int NUM_ELEM = N * N;
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;
endpackage

// File: rtl/mat_result_reader.sv
// mat_result_reader: latches a result matrix on a valid rising edge and streams it out element by element
module mat_result_reader
    import mat_pkg::*;
#(
    parameter int ELEM_W = mat_pkg::ELEM_W,
    parameter int N      = mat_pkg::N
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic [N*N*ELEM_W-1:0]      in_mat,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ELEM_W-1:0]          out_data,
    output logic [3:0]                 out_index,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun
);
    localparam int NUM_ELEM = N * N;
    localparam logic [3:0] LAST_IDX = 4'(NUM_ELEM - 1);

    state_e                     state_q, state_d;
    logic [NUM_ELEM*ELEM_W-1:0] buf_q, buf_d;
    logic [3:0]                 idx_q, idx_d;
    logic                       prev_q, overrun_q, overrun_d;
    logic                       cap;

    // a held-high valid level must not retrigger, so only a low-to-high step captures
    assign cap       = in_valid && !prev_q;
    assign out_valid = state_q == SEND;
    assign out_data  = out_valid ? buf_q[idx_q*ELEM_W +: ELEM_W] : '0;
    assign out_index = idx_q;
    assign out_last  = out_valid && idx_q == LAST_IDX;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign overrun   = overrun_q;

    // next-state: capture in IDLE, advance on each accepted transfer, flag drops while busy
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        idx_d     = idx_q;
        overrun_d = overrun_q | (cap && state_q != IDLE);
        case (state_q)
            IDLE: if (cap) begin
                buf_d   = in_mat;
                idx_d   = '0;
                state_d = SEND;
            end
            SEND: if (out_ready) begin
                idx_d   = idx_q == LAST_IDX ? '0 : idx_q + 4'd1;
                state_d = idx_q == LAST_IDX ? DONE : SEND;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            idx_q     <= '0;
            prev_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            idx_q     <= idx_d;
            prev_q    <= in_valid;
            overrun_q <= overrun_d;
        end
    end
endmodule

// File: tb/tb_mat_result_reader.sv
// tb_mat_result_reader: directed scoreboard bench for the matrix result reader
module tb_mat_result_reader;
    localparam int EW = 17;
    localparam int NE = 9;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               in_valid = 1'b0;
    logic [NE*EW-1:0]   in_mat = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [EW-1:0]      out_data;
    logic [3:0]         out_index;
    logic               out_last;
    logic               busy;
    logic               done;
    logic               overrun;

    int compared = 0;
    int mismatched = 0;
    logic [21:0] sb[$];

    mat_result_reader dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_mat(in_mat),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy), .done(done),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NE*EW-1:0] mk(input int base, input int inc);
        logic [NE*EW-1:0] m;
        for (int i = 0; i < NE; i++) m[i*EW +: EW] = EW'(base + i * inc);
        return m;
    endfunction

    task automatic push_frame(input logic [NE*EW-1:0] m);
        for (int i = 0; i < NE; i++) sb.push_back({4'(i), i == NE - 1, m[i*EW +: EW]});
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() > 0 || busy) && n < 100) begin
            step();
            n++;
        end
        chk("drain_queue_empty", sb.size(), 0);
        chk("drain_idle", busy, 0);
    endtask

    task automatic wait_index(input logic [3:0] idx);
        int n = 0;
        while (out_index !== idx && n < 50) begin
            step();
            n++;
        end
        chk("wait_index", out_index, idx);
    endtask

    // every accepted transfer must match the oldest expected element; idle data must be zero
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_transfer", {out_index, out_last, out_data}, 0);
            else chk("transfer", {10'd0, out_index, out_last, out_data}, {10'd0, sb.pop_front()});
        end else if (!out_valid) begin
            chk("idle_data_zero", {out_data, out_last}, 0);
        end
    end

    initial begin
        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_index", out_index, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        reset_n = 1'b1;
        step();
        step();
        // frame A: elements 1..9 streaming back to back, valid held high afterwards
        in_mat = mk(1, 1);
        push_frame(in_mat);
        in_valid = 1'b1;
        step();
        for (int i = 0; i < NE; i++) begin
            chk("stream_valid", out_valid, 1);
            chk("stream_busy", busy, 1);
            step();
        end
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_valid_low", out_valid, 0);
        step();
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
        for (int i = 0; i < 10; i++) step();
        chk("held_no_retrigger", busy, 0);
        chk("held_no_overrun", overrun, 0);
        chk("held_queue", sb.size(), 0);
        // frame B: all-ones elements after a fresh rising edge
        in_valid = 1'b0;
        step();
        in_mat = mk(17'h1FFFF, 0);
        push_frame(in_mat);
        in_valid = 1'b1;
        step();
        chk("frame_b_start", out_valid, 1);
        in_valid = 1'b0;
        drain();
        // frame C: backpressure while index 4 is presented
        in_mat = mk(1, 1);
        push_frame(in_mat);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_index(4'd4);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 5);
            chk("bp_index", out_index, 4);
            chk("bp_last", out_last, 0);
            step();
        end
        out_ready = 1'b1;
        drain();
        chk("bp_no_overrun", overrun, 0);
        // frame D: second rising edge mid-stream is dropped and flags overrun
        in_mat = mk(10, 1);
        push_frame(in_mat);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_index(4'd3);
        in_mat = mk(100, 3);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("overrun_set", overrun, 1);
        drain();
        chk("overrun_sticky", overrun, 1);
        // frame E: reset mid-stream at index 5
        in_mat = mk(40, 2);
        push_frame(in_mat);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_index(4'd5);
        out_ready = 1'b0;
        reset_n = 1'b0;
        sb.delete();
        step();
        chk("midrst_valid", out_valid, 0);
        chk("midrst_index", out_index, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_overrun", overrun, 0);
        // frame F: valid already high at reset release starts a frame at index 0
        in_mat = mk(7, 5);
        push_frame(in_mat);
        in_valid = 1'b1;
        out_ready = 1'b1;
        reset_n = 1'b1;
        step();
        chk("release_start", out_valid, 1);
        chk("release_index", out_index, 0);
        drain();
        chk("final_overrun", overrun, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
